audio_gain_stage: RTL and testbench
===================================

AUDIO_GAIN_STAGE -- requirements
Module: audio_gain_stage

Interface
REQ-001 Parameter RAMP_STEP, default 1: gain increment or decrement applied per accepted sample.
REQ-002 Parameter GAIN_W, default 8: gain width; unsigned Q1.7, where 128 = unity and 255 ≈ 1.99.
REQ-003 Port clk_100, input, 1: single clock for the block; all logic is in this domain.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port line_in_l, input, 24: signed left sample from the codec interface.
REQ-006 Port line_in_r, input, 24: signed right sample.
REQ-007 Port new_sample, input, 1: one-cycle strobe; line_in_l and line_in_r are valid while it is high.
REQ-008 Port gain_target, input, GAIN_W: requested gain, quasi-static.
REQ-009 Port mute, input, 1: forces the effective target gain to 0.
REQ-010 Port hphone_l, output, 24: signed processed left sample.
REQ-011 Port hphone_r, output, 24: signed processed right sample.
REQ-012 Port hphone_l_valid, output, 1: one-cycle strobe; both outputs are updated in that cycle.
REQ-013 Port gain_cur, output, GAIN_W: gain currently applied.
REQ-014 Port overrun, output, 1: sticky; set when new_sample arrives while the block is busy.
REQ-015 Port clip, output, 1: high together with hphone_l_valid if either channel saturated in that sample.
REQ-016 Port peak_clr, input, 1: clears peak_level.
REQ-017 Port peak_level, output, 23: peak output magnitude since the last clear.

Function
REQ-018 FSM states: IDLE, MUL_L, MUL_R, DONE; these are the only states.
REQ-019 IDLE with new_sample=1 → MUL_L: latch both samples and update gain_cur. MUL_L → MUL_R → DONE → IDLE unconditionally, one cycle each.
REQ-020 Gain update at acceptance: eff = mute ? 0 : gain_target. gain_cur moves toward eff by RAMP_STEP per sample and clamps at eff (no overshoot). When gain_cur equals eff it is unchanged.
REQ-021 A single shared multiplier is used: the left channel in MUL_L and the right channel in MUL_R.
REQ-022 Arithmetic: sample (24b signed) × {1'b0, gain_cur} gives a 33b signed product. Arithmetic shift right by 7 (truncation toward −inf), then saturate to [−8388608, 8388607].
REQ-023 Latency: new_sample sampled at edge E → hphone_l, hphone_r and hphone_l_valid all change at edge E+3. hphone_l_valid is high for exactly one cycle.
REQ-024 hphone_l and hphone_r hold their values between valid strobes.
REQ-025 new_sample while state ≠ IDLE: the sample is discarded, overrun is set (sticky until reset), and the current operation is not disturbed.
REQ-026 clip is registered alongside hphone_l_valid and is 0 in every other cycle.
REQ-027 gain_target changes mid-operation have no effect until the next accepted sample.

Reset
REQ-028 rst_n=0 immediately forces: state IDLE; hphone_l = hphone_r = 0; hphone_l_valid = 0; clip = 0; overrun = 0; peak_level = 0; gain_cur = 0.
REQ-029 Reset asserted mid-operation aborts the operation; no valid strobe is emitted for that sample.
REQ-030 After reset, gain_cur ramps up from 0 (soft start).

Configuration
REQ-031 Macro AUDIO_GAIN_PEAK_EN, when defined: on each valid strobe, peak_level = max(peak_level, |hphone_l|, |hphone_r|). |−8388608| saturates to 8388607 before truncation to 23b. peak_clr has priority over the update in the same cycle.
REQ-032 Without AUDIO_GAIN_PEAK_EN: peak_level is tied to 0, peak_clr is ignored, and no peak registers are synthesized.

Structure
REQ-033 Shared package audio_pkg holds: SAMPLE_W=24; SAMPLE_MAX/SAMPLE_MIN; GAIN_UNITY=128; GAIN_FRAC=7; the FSM state enum.
REQ-034 Sub-module audio_sat_mul holds the combinational multiply, shift and saturate (sample, gain → result, sat flag). It is instantiated once.

Verification
REQ-035 Reset, then gain_target=128 with mute=0 held: after 128 samples with RAMP_STEP=1, gain_cur=128. Input L=0x100000 → hphone_l=0x100000, and valid fires exactly 3 edges after new_sample.
REQ-036 gain_cur=255 (settled), L=0x7FFFFF, R=0x800000 → hphone_l=0x7FFFFF, hphone_r=0x800000, clip=1 with valid.
REQ-037 gain_cur=64, L=−3 → hphone_l=−2 (floor of −1.5); R=5 → hphone_r=2.
REQ-038 new_sample pulsed at E and E+1 → exactly one valid at E+3, overrun=1 afterwards and held.
REQ-039 Settled at 128, mute=1 → gain_cur decreases by 1 per sample to 0, then outputs are 0. Release mute → gain ramps back up to 128.
REQ-040 rst_n deasserted-then-asserted at E+1 after new_sample → no valid, all outputs 0. With AUDIO_GAIN_PEAK_EN: outputs 0x400000 then −0x500000 → peak_level=0x500000, and peak_clr → 0.

Source files
------------

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio gain stage: sample width and limits, gain
// fixed-point format, the FSM state encoding and a magnitude helper used by
// the optional peak meter.
// -----------------------------------------------------------------------------
package audio_pkg;

   localparam int SAMPLE_W   = 24;
   localparam int GAIN_UNITY = 128;   // unsigned Q1.7 value for 1.0
   localparam int GAIN_FRAC  = 7;     // fractional bits of the gain

   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 24'sh7FFFFF;
   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 24'sh800000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_L = 2'd1,
      MUL_R = 2'd2,
      DONE  = 2'd3
   } audio_state_e;

   // Magnitude of a signed sample, truncated to SAMPLE_W-1 bits. The most
   // negative sample has no positive twin, so it reports full scale instead.
   function automatic logic [SAMPLE_W-2:0] mag_sat(input logic signed [SAMPLE_W-1:0] s);
      logic [SAMPLE_W-2:0] m;
      if (s == SAMPLE_MIN) begin
         m = {(SAMPLE_W-1){1'b1}};
      end else if (s[SAMPLE_W-1]) begin
         // two's complement negate; |s| < 2^(SAMPLE_W-1) so the low bits suffice
         m = (~s[SAMPLE_W-2:0]) + {{(SAMPLE_W-2){1'b0}}, 1'b1};
      end else begin
         m = s[SAMPLE_W-2:0];
      end
      return m;
   endfunction

endpackage

// File: rtl/audio_sat_mul.sv
// -----------------------------------------------------------------------------
// audio_sat_mul
// Combinational gain multiply: signed sample times unsigned Q1.7 gain, then an
// arithmetic shift right by GAIN_FRAC (rounds toward -inf) and saturation to
// the signed SAMPLE_W range.
//   sample : signed input sample
//   gain   : unsigned Q1.7 gain
//   result : saturated, scaled sample
//   sat    : high when result was clamped
// -----------------------------------------------------------------------------
module audio_sat_mul
   import audio_pkg::*;
#(
   parameter int GAIN_W = 8
) (
   input  logic signed [SAMPLE_W-1:0] sample,
   input  logic        [GAIN_W-1:0]   gain,
   output logic signed [SAMPLE_W-1:0] result,
   output logic                       sat
);

   localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

   logic signed [PROD_W-1:0]        prod_s;
   logic signed [PROD_W-1:0]        shifted_s;
   logic        [PROD_W-SAMPLE_W:0] high_s;

   // Multiply, scale and clamp to the sample range.
   always_comb begin
      prod_s    = sample * $signed({1'b0, gain});
      shifted_s = prod_s >>> GAIN_FRAC;
      // The value fits when every bit from the sample sign bit upward agrees.
      high_s    = shifted_s[PROD_W-1:SAMPLE_W-1];
      result    = shifted_s[SAMPLE_W-1:0];
      sat       = 1'b0;
      if ((&high_s) || (~|high_s)) begin
         result = shifted_s[SAMPLE_W-1:0];
         sat    = 1'b0;
      end else if (shifted_s[PROD_W-1]) begin
         result = SAMPLE_MIN;
         sat    = 1'b1;
      end else begin
         result = SAMPLE_MAX;
         sat    = 1'b1;
      end
   end

endmodule

// File: rtl/audio_gain_stage.sv
// -----------------------------------------------------------------------------
// audio_gain_stage
// Stereo gain stage with ramped (click-free) gain changes, mute, saturation
// flagging and an optional peak meter. One shared multiplier processes the
// left channel then the right channel; results appear 3 clocks after the
// sample strobe.
//
// Optional feature: define AUDIO_GAIN_PEAK_EN to build the peak meter. Without
// it peak_level is constant 0 and peak_clr is ignored.
//
// Ports
//   clk_100        : block clock
//   rst_n          : asynchronous active-low reset
//   line_in_l/r    : signed input samples, valid while new_sample is high
//   new_sample     : one-cycle input strobe
//   gain_target    : requested gain (unsigned Q1.7)
//   mute           : forces the ramp target to 0
//   hphone_l/r     : signed processed samples, held between strobes
//   hphone_l_valid : one-cycle strobe when hphone_l/r update
//   gain_cur       : gain currently applied
//   overrun        : sticky, a sample arrived while busy
//   clip           : a channel saturated, qualified by hphone_l_valid
//   peak_clr       : clears peak_level
//   peak_level     : peak output magnitude since the last clear
// -----------------------------------------------------------------------------
module audio_gain_stage
   import audio_pkg::*;
#(
   parameter int unsigned RAMP_STEP = 1,
   parameter int          GAIN_W    = 8
) (
   input  logic                       clk_100,
   input  logic                       rst_n,
   input  logic signed [SAMPLE_W-1:0] line_in_l,
   input  logic signed [SAMPLE_W-1:0] line_in_r,
   input  logic                       new_sample,
   input  logic        [GAIN_W-1:0]   gain_target,
   input  logic                       mute,
   output logic signed [SAMPLE_W-1:0] hphone_l,
   output logic signed [SAMPLE_W-1:0] hphone_r,
   output logic                       hphone_l_valid,
   output logic        [GAIN_W-1:0]   gain_cur,
   output logic                       overrun,
   output logic                       clip,
   input  logic                       peak_clr,
   output logic        [SAMPLE_W-2:0] peak_level
);

   localparam logic [GAIN_W:0] STEP_EXT = RAMP_STEP[GAIN_W:0];

   audio_state_e               state_r;
   logic signed [SAMPLE_W-1:0] samp_l_r;
   logic signed [SAMPLE_W-1:0] samp_r_r;
   logic signed [SAMPLE_W-1:0] res_l_r;
   logic signed [SAMPLE_W-1:0] res_r_r;
   logic                       sat_l_r;
   logic                       sat_r_r;
   logic signed [SAMPLE_W-1:0] hphone_l_r;
   logic signed [SAMPLE_W-1:0] hphone_r_r;
   logic                       valid_r;
   logic                       clip_r;
   logic                       overrun_r;
   logic        [GAIN_W-1:0]   gain_cur_r;

   logic        [GAIN_W-1:0]   eff_s;
   logic        [GAIN_W:0]     gap_s;
   logic        [GAIN_W-1:0]   gain_next_s;
   logic signed [SAMPLE_W-1:0] mul_in_s;
   logic signed [SAMPLE_W-1:0] mul_res_s;
   logic                       mul_sat_s;

   // Next gain: step toward the effective target without overshooting it.
   always_comb begin
      eff_s       = mute ? {GAIN_W{1'b0}} : gain_target;
      gap_s       = {(GAIN_W+1){1'b0}};
      gain_next_s = gain_cur_r;
      if (gain_cur_r < eff_s) begin
         gap_s = {1'b0, eff_s} - {1'b0, gain_cur_r};
         if (gap_s > STEP_EXT) begin
            gain_next_s = gain_cur_r + STEP_EXT[GAIN_W-1:0];
         end else begin
            gain_next_s = eff_s;
         end
      end else if (gain_cur_r > eff_s) begin
         gap_s = {1'b0, gain_cur_r} - {1'b0, eff_s};
         if (gap_s > STEP_EXT) begin
            gain_next_s = gain_cur_r - STEP_EXT[GAIN_W-1:0];
         end else begin
            gain_next_s = eff_s;
         end
      end else begin
         gain_next_s = gain_cur_r;
      end
   end

   // Shared multiplier input: right channel only in MUL_R.
   always_comb begin
      mul_in_s = samp_l_r;
      if (state_r == MUL_R) begin
         mul_in_s = samp_r_r;
      end else begin
         mul_in_s = samp_l_r;
      end
   end

   audio_sat_mul #(
      .GAIN_W (GAIN_W)
   ) u_sat_mul (
      .sample (mul_in_s),
      .gain   (gain_cur_r),
      .result (mul_res_s),
      .sat    (mul_sat_s)
   );

   // Sequencer: accept, multiply left, multiply right, publish.
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         samp_l_r   <= {SAMPLE_W{1'b0}};
         samp_r_r   <= {SAMPLE_W{1'b0}};
         res_l_r    <= {SAMPLE_W{1'b0}};
         res_r_r    <= {SAMPLE_W{1'b0}};
         sat_l_r    <= 1'b0;
         sat_r_r    <= 1'b0;
         hphone_l_r <= {SAMPLE_W{1'b0}};
         hphone_r_r <= {SAMPLE_W{1'b0}};
         valid_r    <= 1'b0;
         clip_r     <= 1'b0;
         overrun_r  <= 1'b0;
         gain_cur_r <= {GAIN_W{1'b0}};
      end else begin
         valid_r <= 1'b0;
         clip_r  <= 1'b0;
         // A strobe while busy is dropped; only the sticky flag records it.
         if (new_sample && (state_r != IDLE)) begin
            overrun_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (new_sample) begin
                  samp_l_r   <= line_in_l;
                  samp_r_r   <= line_in_r;
                  gain_cur_r <= gain_next_s;
                  state_r    <= MUL_L;
               end
            end
            MUL_L: begin
               res_l_r <= mul_res_s;
               sat_l_r <= mul_sat_s;
               state_r <= MUL_R;
            end
            MUL_R: begin
               res_r_r <= mul_res_s;
               sat_r_r <= mul_sat_s;
               state_r <= DONE;
            end
            DONE: begin
               hphone_l_r <= res_l_r;
               hphone_r_r <= res_r_r;
               valid_r    <= 1'b1;
               clip_r     <= sat_l_r | sat_r_r;
               state_r    <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign hphone_l       = hphone_l_r;
   assign hphone_r       = hphone_r_r;
   assign hphone_l_valid = valid_r;
   assign clip           = clip_r;
   assign overrun        = overrun_r;
   assign gain_cur       = gain_cur_r;

`ifdef AUDIO_GAIN_PEAK_EN
   logic [SAMPLE_W-2:0] peak_r;
   logic [SAMPLE_W-2:0] mag_l_s;
   logic [SAMPLE_W-2:0] mag_r_s;
   logic [SAMPLE_W-2:0] peak_next_s;

   // Largest of the running peak and both channel magnitudes being published.
   always_comb begin
      mag_l_s     = mag_sat(res_l_r);
      mag_r_s     = mag_sat(res_r_r);
      peak_next_s = (mag_l_s > peak_r) ? mag_l_s : peak_r;
      peak_next_s = (mag_r_s > peak_next_s) ? mag_r_s : peak_next_s;
   end

   // Peak register: clear wins over an update in the same cycle.
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         peak_r <= {(SAMPLE_W-1){1'b0}};
      end else if (peak_clr) begin
         peak_r <= {(SAMPLE_W-1){1'b0}};
      end else if (state_r == DONE) begin
         peak_r <= peak_next_s;
      end
   end

   assign peak_level = peak_r;
`else
   logic peak_clr_unused_s;

   assign peak_clr_unused_s = peak_clr;
   assign peak_level        = {(SAMPLE_W-1){1'b0}};
`endif

endmodule

// File: tb/tb_audio_gain_stage.sv
// -----------------------------------------------------------------------------
// tb_audio_gain_stage
// Scoreboard bench: each accepted sample pushes its hand-computed expected
// output and arrival cycle; a monitor pops and compares on every valid strobe.
// -----------------------------------------------------------------------------
module tb_audio_gain_stage;

   logic               clk_100 = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [23:0] line_in_l = 24'sd0;
   logic signed [23:0] line_in_r = 24'sd0;
   logic               new_sample = 1'b0;
   logic        [7:0]  gain_target = 8'd0;
   logic               mute = 1'b0;
   logic               peak_clr = 1'b0;
   logic signed [23:0] hphone_l;
   logic signed [23:0] hphone_r;
   logic               hphone_l_valid;
   logic        [7:0]  gain_cur;
   logic               overrun;
   logic               clip;
   logic        [22:0] peak_level;

   typedef struct {
      logic signed [23:0] l;
      logic signed [23:0] r;
      logic               c;
      int                 cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

`ifdef AUDIO_GAIN_PEAK_EN
   localparam logic [22:0] PEAK_EXP = 23'h500000;
`else
   localparam logic [22:0] PEAK_EXP = 23'h000000;
`endif

   always #5 clk_100 = ~clk_100;

   always @(posedge clk_100) cyc <= cyc + 1;

   audio_gain_stage #(
      .RAMP_STEP (1),
      .GAIN_W    (8)
   ) dut (
      .clk_100        (clk_100),
      .rst_n          (rst_n),
      .line_in_l      (line_in_l),
      .line_in_r      (line_in_r),
      .new_sample     (new_sample),
      .gain_target    (gain_target),
      .mute           (mute),
      .hphone_l       (hphone_l),
      .hphone_r       (hphone_r),
      .hphone_l_valid (hphone_l_valid),
      .gain_cur       (gain_cur),
      .overrun        (overrun),
      .clip           (clip),
      .peak_clr       (peak_clr),
      .peak_level     (peak_level)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic signed [23:0] el, input logic signed [23:0] er,
                           input logic ec, input int at_cyc);
      exp_t e;
      e.l   = el;
      e.r   = er;
      e.c   = ec;
      e.cyc = at_cyc;
      sb_q.push_back(e);
   endtask

   // Called just after a rising edge; returns just after the edge where the
   // block is back in IDLE-ready position for the next strobe.
   task automatic send(input logic signed [23:0] l, input logic signed [23:0] r,
                       input logic signed [23:0] el, input logic signed [23:0] er,
                       input logic ec);
      push_exp(el, er, ec, cyc + 4);
      line_in_l  = l;
      line_in_r  = r;
      new_sample = 1'b1;
      @(posedge clk_100); #1;
      new_sample = 1'b0;
      repeat (3) @(posedge clk_100);
      #1;
   endtask

   task automatic ramp(input int n);
      for (int i = 0; i < n; i++) send(24'sd0, 24'sd0, 24'sd0, 24'sd0, 1'b0);
   endtask

   // Monitor: compare every valid strobe against the scoreboard head.
   always @(negedge clk_100) begin
      if (hphone_l_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got hphone_l=0x%0h with no expected entry (t=%0t)",
                     hphone_l, $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("hphone_l", hphone_l, mon_e.l);
            chk("hphone_r", hphone_r, mon_e.r);
            chk("clip", clip, mon_e.c);
            chk("latency_cycle", cyc, mon_e.cyc);
         end
      end else begin
         chk("clip_idle", clip, 1'b0);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk_100);
      #1;
      chk("rst_hphone_l", hphone_l, 24'sd0);
      chk("rst_hphone_r", hphone_r, 24'sd0);
      chk("rst_valid", hphone_l_valid, 1'b0);
      chk("rst_clip", clip, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_gain_cur", gain_cur, 8'd0);
      chk("rst_peak", peak_level, 23'd0);

      // Soft start to unity.
      rst_n       = 1'b1;
      gain_target = 8'd128;
      mute        = 1'b0;
      @(posedge clk_100); #1;
      send(24'sd0, 24'sd0, 24'sd0, 24'sd0, 1'b0);
      chk("gain_first_step", gain_cur, 8'd1);
      ramp(127);
      chk("gain_unity", gain_cur, 8'd128);
      send(24'sh100000, -24'sh100000, 24'sh100000, -24'sh100000, 1'b0);

      // Maximum gain: saturation on both rails, then an unclipped pair.
      gain_target = 8'd255;
      ramp(127);
      chk("gain_max", gain_cur, 8'd255);
      send(24'sh7FFFFF, 24'sh800000, 24'sh7FFFFF, 24'sh800000, 1'b1);
      send(24'sd256, -24'sd256, 24'sd510, -24'sd510, 1'b0);

      // Half gain: floor rounding; target change mid-operation is ignored.
      gain_target = 8'd64;
      ramp(191);
      chk("gain_half", gain_cur, 8'd64);
      push_exp(-24'sd2, 24'sd2, 1'b0, cyc + 4);
      line_in_l  = -24'sd3;
      line_in_r  = 24'sd5;
      new_sample = 1'b1;
      @(posedge clk_100); #1;
      new_sample  = 1'b0;
      gain_target = 8'd255;
      repeat (3) @(posedge clk_100);
      #1;
      chk("gain_mid_change", gain_cur, 8'd64);
      gain_target = 8'd64;
      repeat (2) @(posedge clk_100);
      #1;
      chk("hold_hphone_l", hphone_l, -24'sd2);
      chk("hold_hphone_r", hphone_r, 24'sd2);
      chk("hold_valid_low", hphone_l_valid, 1'b0);

      // Overrun: strobe on two consecutive edges, second one discarded.
      chk("overrun_clear", overrun, 1'b0);
      push_exp(24'sd4, -24'sd4, 1'b0, cyc + 4);
      line_in_l  = 24'sd8;
      line_in_r  = -24'sd8;
      new_sample = 1'b1;
      @(posedge clk_100); #1;
      line_in_l = 24'sh7FFFFF;
      line_in_r = 24'sh7FFFFF;
      @(posedge clk_100); #1;
      new_sample = 1'b0;
      repeat (2) @(posedge clk_100);
      #1;
      chk("overrun_set", overrun, 1'b1);
      repeat (4) @(posedge clk_100);
      #1;
      chk("overrun_sticky", overrun, 1'b1);

      // Mute ramps down to silence, release ramps back to unity.
      gain_target = 8'd128;
      ramp(64);
      chk("gain_back_unity", gain_cur, 8'd128);
      mute = 1'b1;
      send(24'sd0, 24'sd0, 24'sd0, 24'sd0, 1'b0);
      chk("mute_first_step", gain_cur, 8'd127);
      ramp(127);
      chk("mute_gain_zero", gain_cur, 8'd0);
      send(24'sh100000, 24'sh100000, 24'sd0, 24'sd0, 1'b0);
      mute = 1'b0;
      send(24'sh100000, -24'sh100000, 24'sh002000, -24'sh002000, 1'b0);
      ramp(127);
      chk("unmute_gain_unity", gain_cur, 8'd128);
      send(24'sh100000, -24'sh100000, 24'sh100000, -24'sh100000, 1'b0);
      chk("overrun_still_set", overrun, 1'b1);

      // Reset one cycle into an operation: no strobe, everything cleared.
      line_in_l  = 24'sh200000;
      line_in_r  = 24'sh200000;
      new_sample = 1'b1;
      @(posedge clk_100); #1;
      new_sample = 1'b0;
      @(posedge clk_100); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_hphone_l", hphone_l, 24'sd0);
      chk("abort_hphone_r", hphone_r, 24'sd0);
      chk("abort_valid", hphone_l_valid, 1'b0);
      chk("abort_overrun", overrun, 1'b0);
      chk("abort_gain_cur", gain_cur, 8'd0);
      repeat (2) @(posedge clk_100);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk_100);
      #1;

      // Peak meter (constant zero when the feature is not built).
      ramp(128);
      chk("gain_after_reset", gain_cur, 8'd128);
      send(24'sh400000, 24'sd0, 24'sh400000, 24'sd0, 1'b0);
      send(-24'sh500000, 24'sd0, -24'sh500000, 24'sd0, 1'b0);
      chk("peak_level", peak_level, PEAK_EXP);
      peak_clr = 1'b1;
      @(posedge clk_100); #1;
      peak_clr = 1'b0;
      chk("peak_cleared", peak_level, 23'd0);

      repeat (6) @(posedge clk_100);
      #1;
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
